lutram_scan_ctrl: RTL and testbench

- Self-checking sequencer for one behavioural single-bit-wide LUTRAM (RAMS64E / RAM64X1S-class, asynchronous read, synchronous write).
- On start, sweeps every address and compares read data against the expected INIT image.
- Optionally writes the inverted image and re-verifies it.
- Reports pass/fail, a saturating error count and the first failing address to the board-level test top, replacing tied-high address pins with a driven sweep.

---
 rtl/lutram_scan_ctrl_pkg.sv | 22 ++
 rtl/lutram_scan_ctrl_if.sv | 15 +
 rtl/lutram_scan_chk.sv | 39 +++
 rtl/lutram_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_lutram_scan_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lutram_scan_ctrl_pkg.sv
// Shared definitions for the LUTRAM scan controller: phase codes reported on
// phase_o, the controller state type and a default INIT image.
package lutram_test_pkg;

  localparam logic [1:0] PH_INIT   = 2'd0;
  localparam logic [1:0] PH_WRITE  = 2'd1;
  localparam logic [1:0] PH_VERIFY = 2'd2;
  localparam logic [1:0] PH_IDLE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_INIT,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } scan_state_e;

  // Reference image for boards that use the widest (256-entry) LUTRAM.
  localparam logic [255:0] DEFAULT_INIT =
    256'hDEADBEEF0150BAD0CAFEF00D0F0FFFFF0123456789ABCDEFFEDCBA9876543210;

endpackage

// File: rtl/lutram_scan_ctrl_if.sv
// Port bundle between the scan controller and a single-bit LUTRAM:
// shared address, write strobe, write data and asynchronous read data.
interface lutram_scan_ctrl_if #(
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              d;
  logic              q;

  modport master (output addr, output we, output d, input q);
  modport slave  (input addr, input we, input d, output q);

endinterface

// File: rtl/lutram_scan_chk.sv
// Result collector shared by the INIT check and VERIFY sweeps: a saturating
// mismatch counter plus a latch holding the address of the first mismatch.
module lutram_scan_chk #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = ADDR_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              sample_en_i,
  input  logic              mismatch_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              first_err_vld_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  // Count mismatches (sticking at all-ones) and remember only the first address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o        <= '0;
      first_err_vld_o  <= 1'b0;
      first_err_addr_o <= '0;
    end else if (clear_i) begin
      err_cnt_o        <= '0;
      first_err_vld_o  <= 1'b0;
      first_err_addr_o <= '0;
    end else if (sample_en_i && mismatch_i) begin
      if (err_cnt_o != {CNT_W{1'b1}}) begin
        err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
      if (!first_err_vld_o) begin
        first_err_vld_o  <= 1'b1;
        first_err_addr_o <= addr_i;
      end
    end
  end

endmodule

// File: rtl/lutram_scan_ctrl.sv
// Self-checking sweep sequencer for one single-bit LUTRAM.
// A start pulse walks every address once, comparing the asynchronous read
// data against EXP_INIT. With LUTRAM_SCAN_WRITE_EN defined, the sweep goes on
// to write the inverted image and re-verify it. Without the macro, the INIT
// check goes straight to DONE and the write port is held at zero.
module lutram_scan_ctrl
  import lutram_test_pkg::*;
#(
  parameter int                     ADDR_W   = 6,
  parameter logic [(2**ADDR_W)-1:0] EXP_INIT = {(2**ADDR_W){1'b0}},
  parameter int                     CNT_W    = ADDR_W + 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  lutram_scan_ctrl_if.master ram,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic               first_err_vld_o,
  output logic [ADDR_W-1:0]  first_err_addr_o,
  output logic [1:0]         phase_o
);

  scan_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              at_last;
  logic              exp_bit;
  logic              mismatch;
  logic              sample_en;
  logic              accept_start;

  assign ram.addr = addr_q;
  assign at_last  = (addr_q == {ADDR_W{1'b1}});
  assign exp_bit  = EXP_INIT[addr_q];

  // VERIFY expects the inverted image, so a read equal to the INIT bit is the error there.
  assign mismatch = (state_q == ST_VERIFY) ? (ram.q == exp_bit) : (ram.q != exp_bit);

  // An abort on the same edge freezes the results, so that edge's read is discarded.
  assign sample_en    = ((state_q == ST_CHK_INIT) || (state_q == ST_VERIFY)) && !abort_i;
  assign accept_start = start_i && !abort_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign pass_o = done_o && (err_cnt_o == '0);

`ifdef LUTRAM_SCAN_WRITE_EN
  logic we_q;
  assign ram.we = we_q;
  assign ram.d  = we_q & ~exp_bit;
`else
  assign ram.we = 1'b0;
  assign ram.d  = 1'b0;
`endif

  // Sweep sequencer: one address per cycle in each phase, abort overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      phase_o <= PH_IDLE;
`ifdef LUTRAM_SCAN_WRITE_EN
      we_q    <= 1'b0;
`endif
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      phase_o <= PH_IDLE;
`ifdef LUTRAM_SCAN_WRITE_EN
      we_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q <= ST_CHK_INIT;
            addr_q  <= '0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            phase_o <= PH_INIT;
          end
        end
        ST_CHK_INIT: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (at_last) begin
`ifdef LUTRAM_SCAN_WRITE_EN
            state_q <= ST_WRITE;
            phase_o <= PH_WRITE;
            we_q    <= 1'b1;
`else
            state_q <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            phase_o <= PH_IDLE;
`endif
          end
        end
`ifdef LUTRAM_SCAN_WRITE_EN
        ST_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (at_last) begin
            state_q <= ST_VERIFY;
            phase_o <= PH_VERIFY;
            we_q    <= 1'b0;
          end
        end
        ST_VERIFY: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (at_last) begin
            state_q <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            phase_o <= PH_IDLE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          phase_o <= PH_IDLE;
        end
      endcase
    end
  end

  lutram_scan_chk #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (accept_start),
    .sample_en_i      (sample_en),
    .mismatch_i       (mismatch),
    .addr_i           (addr_q),
    .err_cnt_o        (err_cnt_o),
    .first_err_vld_o  (first_err_vld_o),
    .first_err_addr_o (first_err_addr_o)
  );

endmodule

// File: tb/tb_lutram_scan_ctrl.sv
// Bench for lutram_scan_ctrl: a behavioural 64x1 LUTRAM with a stuck-write
// option, a second instance with a narrow counter against a fully wrong RAM,
// and an image-level reference model of the whole sweep.
module tb_lutram_scan_ctrl;
  import lutram_test_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 8;
  localparam int SAT_W  = 4;
  localparam logic [63:0] EXP = 64'h0123456789ABCDEF;
`ifdef LUTRAM_SCAN_WRITE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int LAT    = FEAT ? 3 * DEPTH + 1 : DEPTH + 1;
  localparam int WE_EXP = FEAT ? DEPTH : 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lutram_scan_ctrl_if #(.ADDR_W(ADDR_W)) ram_bus ();
  lutram_scan_ctrl_if #(.ADDR_W(ADDR_W)) sat_bus ();

  logic              busy, done, pass, first_vld;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_addr;
  logic [1:0]        phase;
  logic              sat_busy, sat_done, sat_pass, sat_vld;
  logic [SAT_W-1:0]  sat_err;
  logic [ADDR_W-1:0] sat_first;
  logic [1:0]        sat_phase;

  lutram_scan_ctrl #(.ADDR_W(ADDR_W), .EXP_INIT(EXP), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .ram(ram_bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .first_err_vld_o(first_vld), .first_err_addr_o(first_addr), .phase_o(phase)
  );

  lutram_scan_ctrl #(.ADDR_W(ADDR_W), .EXP_INIT(EXP), .CNT_W(SAT_W)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .ram(sat_bus),
    .busy_o(sat_busy), .done_o(sat_done), .pass_o(sat_pass), .err_cnt_o(sat_err),
    .first_err_vld_o(sat_vld), .first_err_addr_o(sat_first), .phase_o(sat_phase)
  );

  // Behavioural LUTRAM: asynchronous read, synchronous write, bench-side load port.
  logic [63:0] ram_mem;
  logic [63:0] load_val = '0;
  logic        load_req = 1'b0;
  logic        ram_stuck = 1'b0;
  always @(posedge clk) begin
    if (load_req) ram_mem <= load_val;
    else if (ram_bus.we && !ram_stuck) ram_mem[ram_bus.addr] <= ram_bus.d;
  end
  assign ram_bus.q = ram_mem[ram_bus.addr];

  // Second RAM permanently holds the inverted image and never accepts writes.
  wire [63:0] sat_img = ~EXP;
  assign sat_bus.q = sat_img[sat_bus.addr];

  // Image-level model: count differing bits per sweep, saturate, lowest index first.
  function automatic void model_scan(input logic [63:0] img, input bit stuck, input int cw,
                                     output int ecnt, output bit evld, output int efirst,
                                     output logic [63:0] eimg);
    logic [63:0] e;
    logic [63:0] inv;
    int errs;
    int maxv;
    e = EXP;
    inv = ~EXP;
    errs = 0;
    evld = 1'b0;
    efirst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (img[i] != e[i]) begin
        errs++;
        if (!evld) begin evld = 1'b1; efirst = i; end
      end
    end
    eimg = img;
    if (FEAT) begin
      if (!stuck) eimg = inv;
      for (int i = 0; i < DEPTH; i++) begin
        if (eimg[i] != inv[i]) begin
          errs++;
          if (!evld) begin evld = 1'b1; efirst = i; end
        end
      end
    end
    maxv = (1 << cw) - 1;
    ecnt = (errs > maxv) ? maxv : errs;
  endfunction

  task automatic load_ram(input logic [63:0] img, input bit stuck);
    @(posedge clk); #1;
    load_val = img;
    ram_stuck = stuck;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Load an image, pulse start and follow the sweep until done (bounded).
  task automatic run_scan(input logic [63:0] img, input bit stuck, output int cyc,
                          output int wec, output bit saw_wv, output bit acc_ok);
    load_ram(img, stuck);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    wec = 0;
    saw_wv = 1'b0;
    acc_ok = busy && !done && !first_vld && (err_cnt == '0) && (phase == 2'd0);
    while (!done && cyc < 4 * DEPTH + 10) begin
      if (ram_bus.we) wec++;
      if (phase == 2'd1 || phase == 2'd2) saw_wv = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [27:0] v;
    #12;
    v = {busy, done, pass, first_vld, ram_bus.we, ram_bus.d, phase, err_cnt, first_addr, ram_bus.addr};
    checks++;
    if (v !== {6'b0, 2'b11, 20'b0}) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h, expected %h", v, {6'b0, 2'b11, 20'b0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    int cyc, wec, ecnt, efirst;
    bit saw, acc, evld;
    logic [63:0] eimg;
    model_scan(EXP, 1'b0, CNT_W, ecnt, evld, efirst, eimg);
    run_scan(EXP, 1'b0, cyc, wec, saw, acc);
    checks++;
    if (cyc !== LAT) begin fails++; $display("[TB] FAIL clean_latency: got %0d, expected %0d", cyc, LAT); end
    checks++;
    if (acc !== 1'b1) begin fails++; $display("[TB] FAIL clean_accept: got %b, expected 1", acc); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL clean_done: got done=%b busy=%b, expected 1/0", done, busy); end
    checks++;
    if (pass !== (ecnt == 0)) begin fails++; $display("[TB] FAIL clean_pass: got %b, expected %b", pass, ecnt == 0); end
    checks++;
    if (err_cnt !== CNT_W'(ecnt)) begin fails++; $display("[TB] FAIL clean_err_cnt: got %0d, expected %0d", err_cnt, ecnt); end
    checks++;
    if (wec !== WE_EXP) begin fails++; $display("[TB] FAIL clean_we_cycles: got %0d, expected %0d", wec, WE_EXP); end
    checks++;
    if (saw !== FEAT) begin fails++; $display("[TB] FAIL clean_phase_seen: got %b, expected %b", saw, FEAT); end
    checks++;
    if (ram_mem !== eimg) begin fails++; $display("[TB] FAIL clean_ram_image: got %h, expected %h", ram_mem, eimg); end
  endtask

  task automatic test_single_fault();
    int cyc, wec, ecnt, efirst;
    bit saw, acc, evld;
    logic [63:0] eimg, img;
    img = EXP ^ (64'd1 << 42);
    model_scan(img, 1'b0, CNT_W, ecnt, evld, efirst, eimg);
    run_scan(img, 1'b0, cyc, wec, saw, acc);
    checks++;
    if (err_cnt !== CNT_W'(ecnt)) begin fails++; $display("[TB] FAIL single_err_cnt: got %0d, expected %0d", err_cnt, ecnt); end
    checks++;
    if (first_vld !== evld || first_addr !== ADDR_W'(efirst)) begin
      fails++; $display("[TB] FAIL single_first: got vld=%b addr=%0d, expected vld=%b addr=%0d", first_vld, first_addr, evld, efirst);
    end
    checks++;
    if (pass !== 1'b0) begin fails++; $display("[TB] FAIL single_pass: got %b, expected 0", pass); end
  endtask

  task automatic test_full_fault();
    int cyc, wec, ecnt, efirst, scnt, sfirst;
    bit saw, acc, evld, svld;
    logic [63:0] eimg, simg;
    model_scan(~EXP, 1'b0, CNT_W, ecnt, evld, efirst, eimg);
    model_scan(~EXP, 1'b1, SAT_W, scnt, svld, sfirst, simg);
    run_scan(~EXP, 1'b0, cyc, wec, saw, acc);
    checks++;
    if (err_cnt !== CNT_W'(ecnt)) begin fails++; $display("[TB] FAIL full_err_cnt: got %0d, expected %0d", err_cnt, ecnt); end
    checks++;
    if (first_addr !== ADDR_W'(efirst) || first_vld !== evld) begin
      fails++; $display("[TB] FAIL full_first: got vld=%b addr=%0d, expected vld=%b addr=%0d", first_vld, first_addr, evld, efirst);
    end
    checks++;
    if (sat_err !== SAT_W'(scnt)) begin fails++; $display("[TB] FAIL sat_err_cnt: got %0d, expected %0d", sat_err, scnt); end
    checks++;
    if (sat_done !== 1'b1 || sat_pass !== 1'b0 || sat_vld !== svld || sat_first !== ADDR_W'(sfirst)) begin
      fails++; $display("[TB] FAIL sat_status: got done=%b pass=%b vld=%b first=%0d, expected 1/0/%b/%0d",
                        sat_done, sat_pass, sat_vld, sat_first, svld, sfirst);
    end
  endtask

`ifdef LUTRAM_SCAN_WRITE_EN
  task automatic test_stuck_write();
    int cyc, wec, ecnt, efirst;
    bit saw, acc, evld;
    logic [63:0] eimg;
    model_scan(EXP, 1'b1, CNT_W, ecnt, evld, efirst, eimg);
    run_scan(EXP, 1'b1, cyc, wec, saw, acc);
    checks++;
    if (err_cnt !== CNT_W'(ecnt) || first_addr !== ADDR_W'(efirst)) begin
      fails++; $display("[TB] FAIL stuck_write: got cnt=%0d first=%0d, expected cnt=%0d first=%0d", err_cnt, first_addr, ecnt, efirst);
    end
    checks++;
    if (ram_mem !== EXP) begin fails++; $display("[TB] FAIL stuck_ram_image: got %h, expected %h", ram_mem, EXP); end
  endtask
`endif

  task automatic test_random();
    int cyc, wec, ecnt, efirst;
    bit saw, acc, evld, stuck;
    logic [63:0] eimg, img, mask;
    for (int n = 0; n < 8; n++) begin
      mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      img = EXP ^ mask;
      stuck = FEAT && ($urandom_range(0, 1) == 1);
      model_scan(img, stuck, CNT_W, ecnt, evld, efirst, eimg);
      run_scan(img, stuck, cyc, wec, saw, acc);
      checks++;
      if (err_cnt !== CNT_W'(ecnt) || pass !== (ecnt == 0)) begin
        fails++; $display("[TB] FAIL random_%0d_count: got cnt=%0d pass=%b, expected cnt=%0d pass=%b", n, err_cnt, pass, ecnt, ecnt == 0);
      end
      checks++;
      if (first_vld !== evld || first_addr !== ADDR_W'(efirst)) begin
        fails++; $display("[TB] FAIL random_%0d_first: got vld=%b addr=%0d, expected vld=%b addr=%0d", n, first_vld, first_addr, evld, efirst);
      end
      checks++;
      if (cyc !== LAT || ram_mem !== eimg) begin
        fails++; $display("[TB] FAIL random_%0d_run: got cyc=%0d ram=%h, expected cyc=%0d ram=%h", n, cyc, ram_mem, LAT, eimg);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, wec;
    bit saw, acc;
    run_scan(~EXP, 1'b0, cyc, wec, saw, acc);
    run_scan(EXP, 1'b0, cyc, wec, saw, acc);
    checks++;
    if (acc !== 1'b1) begin fails++; $display("[TB] FAIL b2b_clear_on_start: got %b, expected 1", acc); end
    checks++;
    if (cyc !== LAT || pass !== 1'b1 || err_cnt !== '0) begin
      fails++; $display("[TB] FAIL b2b_result: got cyc=%0d pass=%b cnt=%0d, expected cyc=%0d pass=1 cnt=0", cyc, pass, err_cnt, LAT);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    load_ram(EXP, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 4 * DEPTH + 10) begin
      start = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== LAT) begin fails++; $display("[TB] FAIL start_while_busy: got latency %0d, expected %0d", cyc, LAT); end
  endtask

  task automatic test_abort();
    int k;
    load_ram(EXP ^ (64'd1 << 3) ^ (64'd1 << 12), 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (ram_bus.addr != 6'd10 && k < DEPTH) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (ram_bus.addr !== 6'd10) begin fails++; $display("[TB] FAIL abort_reach_addr: got %0d, expected 10", ram_bus.addr); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, done, ram_bus.we, phase} !== 5'b00011) begin
      fails++; $display("[TB] FAIL abort_idle: got busy/done/we/phase=%b, expected 00011", {busy, done, ram_bus.we, phase});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== 8'd1 || first_addr !== 6'd3 || done !== 1'b0) begin
      fails++; $display("[TB] FAIL abort_frozen: got cnt=%0d first=%0d done=%b, expected 1/3/0", err_cnt, first_addr, done);
    end
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || phase !== 2'd3 || err_cnt !== 8'd1) begin
      fails++; $display("[TB] FAIL abort_beats_start: got busy=%b phase=%0d cnt=%0d, expected 0/3/1", busy, phase, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] v;
    load_ram(EXP ^ 64'd1, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (FEAT ? DEPTH + 10 : 10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || ram_bus.we !== FEAT || err_cnt !== 8'd1) begin
      fails++; $display("[TB] FAIL mid_scan_state: got busy=%b we=%b cnt=%0d, expected 1/%b/1", busy, ram_bus.we, err_cnt, FEAT);
    end
    #2 rst_n = 1'b0;
    #1;
    v = {busy, done, pass, first_vld, ram_bus.we, ram_bus.d, phase, err_cnt, first_addr, ram_bus.addr};
    checks++;
    if (v !== {6'b0, 2'b11, 20'b0}) begin
      fails++; $display("[TB] FAIL async_reset_mid: got %h, expected %h", v, {6'b0, 2'b11, 20'b0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_clean();
    test_single_fault();
    test_full_fault();
`ifdef LUTRAM_SCAN_WRITE_EN
    test_stuck_write();
`endif
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
